// File: rtl/alaw_decoder_pkg.sv
// Shared A-law field positions and constants for the decoder pipeline.
// Stage-1 bundle carries sign, segment and biased mantissa base.
package alaw_decoder_pkg;

    localparam logic [7:0] ALAW_INV_MASK  = 8'h55;
    localparam int         ALAW_SIGN_BIT  = 7;
    localparam int         ALAW_EXP_MSB   = 6;
    localparam int         ALAW_EXP_LSB   = 4;
    localparam int         ALAW_MANT_MSB  = 3;
    localparam int         ALAW_MANT_LSB  = 0;
    localparam int         ALAW_MAG12_MAX = 4032;
    localparam logic [5:0] ALAW_SEG_BIAS  = 6'd32;

    typedef struct packed {
        logic       sign;
        logic [2:0] exp;
        logic [5:0] base;
    } s1_t;

endpackage

// File: rtl/alaw_decoder_pipe_reg.sv
// Width-parameterised valid/ready register slice; payload only
// updates when a valid word is taken, so it holds while idle.
module alaw_decoder_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] up_data,
    input  logic         up_valid,
    output logic         up_ready,
    output logic [W-1:0] dn_data,
    output logic         dn_valid,
    input  logic         dn_ready
);

    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/alaw_decoder.sv
// A-law to linear expander: stage 1 splits the code into fields,
// stage 2 registers the shifted and signed linear sample.
module alaw_decoder
    import alaw_decoder_pkg::*;
#(
    parameter int         DATA_IN_W  = 8,
    parameter int         DATA_OUT_W = 15,
    parameter logic [7:0] INV_MASK   = ALAW_INV_MASK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_IN_W-1:0]  data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_OUT_W-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out
);

    localparam int MAG_SHIFT = DATA_OUT_W - 13;

    logic [DATA_IN_W-1:0]  code;
    s1_t                   s1_d;
    s1_t                   s1_q;
    logic                  v1;
    logic                  s2_ready;
    logic [11:0]           mag12;
    logic [DATA_OUT_W-1:0] mag;
    logic [DATA_OUT_W-1:0] lin;

    assign code = data_in ^ INV_MASK;

    always_comb begin
        s1_d.sign = code[ALAW_SIGN_BIT];
        s1_d.exp  = code[ALAW_EXP_MSB:ALAW_EXP_LSB];
        s1_d.base = {1'b0, code[ALAW_MANT_MSB:ALAW_MANT_LSB], 1'b1};
        // Non-zero segments carry an implied leading one
        if (s1_d.exp != 3'd0) begin
            s1_d.base = s1_d.base + ALAW_SEG_BIAS;
        end
    end

    alaw_decoder_pipe_reg #(
        .W($bits(s1_t))
    ) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .up_data  (s1_d),
        .up_valid (valid_in),
        .up_ready (ready_in),
        .dn_data  (s1_q),
        .dn_valid (v1),
        .dn_ready (s2_ready)
    );

    always_comb begin
        mag12 = {6'd0, s1_q.base};
        if (s1_q.exp != 3'd0) begin
            mag12 = mag12 << (s1_q.exp - 3'd1);
        end
        mag = {{(DATA_OUT_W-12){1'b0}}, mag12} << MAG_SHIFT;
        lin = s1_q.sign ? mag : -mag;
    end

    alaw_decoder_pipe_reg #(
        .W(DATA_OUT_W)
    ) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .up_data  (lin),
        .up_valid (v1),
        .up_ready (s2_ready),
        .dn_data  (data_out),
        .dn_valid (valid_out),
        .dn_ready (ready_out)
    );

endmodule

// File: tb/tb_alaw_decoder.sv
// Bench for alaw_decoder: directed codes, full sweep, stalls,
// random handshakes and mid-stream reset against an arithmetic model.
module tb_alaw_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [14:0] data_out;
    logic        valid_out;
    logic        ready_out = 1'b1;

    int          tests = 0;
    int          fails = 0;
    int          in_cnt = 0;
    int          out_cnt = 0;
    logic        acc = 1'b0;
    logic [7:0]  q[$];
    logic        have_prev = 1'b0;
    logic        prev_vo = 1'b0;
    logic        prev_ro = 1'b0;
    logic [14:0] prev_do = '0;

    logic [7:0]  t1_code[5] = '{8'hD5, 8'h55, 8'hC5, 8'hAA, 8'h2A};
    logic [14:0] t1_exp[5]  = '{15'h0004, 15'h7FFC, 15'h0084,
                                15'h3F00, 15'h4100};

    alaw_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ref_decode(logic [7:0] code);
        int c, e, m, mag;
        c = int'(code ^ 8'h55);
        e = (c >> 4) & 7;
        m = c & 15;
        if (e == 0) mag = 2 * m + 1;
        else mag = (2 * m + 33) * (1 << (e - 1));
        mag = mag * 4;
        return (c & 128) != 0 ? 15'(mag) : 15'(32768 - mag);
    endfunction

    function automatic logic [7:0] ref_encode(logic [14:0] v);
        int s, mag, e, m;
        s = v[14] ? 0 : 1;
        mag = v[14] ? 32768 - int'(v) : int'(v);
        mag = mag / 4;
        if (mag < 32) begin
            e = 0;
            m = mag / 2;
        end else begin
            e = 1;
            while (mag >= (32 << e)) e++;
            m = (mag >> e) & 15;
        end
        return 8'((s << 7) | (e << 4) | m) ^ 8'h55;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at negedge, advance, settle
    task automatic step();
        logic [7:0] c;
        logic       in_rst;
        @(negedge clk);
        acc = 1'b0;
        in_rst = rst;
        if (!in_rst) begin
            if (have_prev && prev_vo && !prev_ro) begin
                check("hold_valid", 32'(valid_out), 32'd1);
                check("hold_data", 32'(data_out), 32'(prev_do));
            end
            if (have_prev && !prev_vo && !valid_out)
                check("idle_data", 32'(data_out), 32'(prev_do));
            if (valid_out && ready_out) begin
                check("out_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    c = q.pop_front();
                    check("data", 32'(data_out), 32'(ref_decode(c)));
                    check("roundtrip", 32'(ref_encode(data_out)), 32'(c));
                end
                out_cnt++;
            end
            if (valid_in && ready_in) begin
                q.push_back(data_in);
                acc = 1'b1;
                in_cnt++;
            end
        end
        prev_vo = valid_out;
        prev_ro = ready_out;
        prev_do = data_out;
        have_prev = !in_rst;
        @(posedge clk);
        #1;
        if (in_rst) q.delete();
    endtask

    initial begin
        int base, idx, cyc;
        logic saw_low;

        step();
        step();
        rst = 1'b0;
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_ready_in", 32'(ready_in), 32'd1);

        // Directed codes and two-edge latency
        ready_out = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_in = t1_code[k];
            valid_in = 1'b1;
            step();
            check("t1_accept", 32'(acc), 32'd1);
            valid_in = 1'b0;
            check("t1_lat_early", 32'(valid_out), 32'd0);
            step();
            check("t1_lat", 32'(valid_out), 32'd1);
            check("t1_value", 32'(data_out), 32'(t1_exp[k]));
            step();
            check("t1_clear", 32'(valid_out), 32'd0);
        end

        // All 256 codes back-to-back
        base = out_cnt;
        for (int i = 0; i < 256; i++) begin
            data_in = 8'(i);
            valid_in = 1'b1;
            check("t2_ready_in", 32'(ready_in), 32'd1);
            step();
            if (i >= 1) check("t2_stream", 32'(valid_out), 32'd1);
        end
        valid_in = 1'b0;
        repeat (3) step();
        check("t2_count", 32'(out_cnt - base), 32'd256);

        // Backpressure mid-stream
        base = out_cnt;
        idx = 0;
        saw_low = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            ready_out = (cyc >= 6 && cyc < 11) ? 1'b0 : 1'b1;
            valid_in = idx < 16;
            data_in = 8'(idx);
            if (!ready_in) saw_low = 1'b1;
            step();
            if (acc) idx++;
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        check("t3_ready_low", 32'(saw_low), 32'd1);
        check("t3_sent", 32'(idx), 32'd16);
        check("t3_count", 32'(out_cnt - base), 32'd16);
        check("t3_empty", 32'(q.size()), 32'd0);

        // Random handshakes, 10k codes
        idx = 0;
        cyc = 0;
        while (idx < 10000 && cyc < 60000) begin
            valid_in = 1'($urandom % 2);
            data_in = 8'($urandom);
            ready_out = 1'($urandom % 2);
            step();
            if (acc) idx++;
            cyc++;
        end
        check("t4_sent", 32'(idx), 32'd10000);
        valid_in = 1'b0;
        ready_out = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 10) begin
            step();
            cyc++;
        end
        check("t4_drained", 32'(q.size()), 32'd0);
        check("t4_balance", 32'(out_cnt), 32'(in_cnt));

        // Reset with two samples in flight
        ready_out = 1'b0;
        valid_in = 1'b1;
        data_in = 8'h3C;
        step();
        data_in = 8'h7E;
        step();
        valid_in = 1'b0;
        check("t5_full", 32'(valid_out), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_valid_out", 32'(valid_out), 32'd0);
        check("t5_data_out", 32'(data_out), 32'd0);
        ready_out = 1'b1;
        step();
        check("t5_idle", 32'(valid_out), 32'd0);
        base = out_cnt;
        data_in = 8'h12;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        check("t5_first", 32'(data_out), 32'(ref_decode(8'h12)));
        step();
        check("t5_count", 32'(out_cnt - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
